// File: rtl/ow_slave_rom_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ow_slave_rom_if : byte-wide function-layer port of the 1-Wire slave  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface ow_slave_rom_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;

  modport slave (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_load
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_load
  );
endinterface
`default_nettype wire

// File: rtl/ow_slave_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ow_slave_rom : 1-Wire responder - reset/presence, ROM commands, byte  |
// | rx/tx toward the device function layer.            Revision 1.0      |
// +----------------------------------------------------------------------+
module ow_slave_rom #(
  parameter logic [63:0] ROM_ID   = 64'hA2000000_12345628,
  parameter int          T_RSTMIN = 400,
  parameter int          T_PDHIGH = 30,
  parameter int          T_PDLOW  = 120,
  parameter int          T_SAMPLE = 30,
  parameter int          T_HOLD0  = 45
) (
  input  wire logic      clk,
  input  wire logic      local_reset,
  input  wire logic      ow_in,
  output logic           ow_pull,
  input  wire logic      alarm,
  output logic           selected,
  output logic           reset_seen,
  output logic           cmd_error,
  ow_slave_rom_if.slave  fn
);

  localparam int c_tmr_max  = (T_PDHIGH > T_PDLOW) ? T_PDHIGH : T_PDLOW;
  localparam int c_slot_max = (T_SAMPLE > T_HOLD0) ? T_SAMPLE : T_HOLD0;
  localparam int c_low_w    = $clog2(T_RSTMIN + 1);
  localparam int c_tmr_w    = $clog2(c_tmr_max + 1);
  localparam int c_slot_w   = $clog2(c_slot_max + 2);

  localparam logic [c_low_w-1:0]  c_low_sat    = c_low_w'(T_RSTMIN);
  localparam logic [c_low_w-1:0]  c_low_hit    = c_low_w'(T_RSTMIN - 1);
  localparam logic [c_tmr_w-1:0]  c_pdhigh_end = c_tmr_w'(T_PDHIGH - 1);
  localparam logic [c_tmr_w-1:0]  c_pdlow_end  = c_tmr_w'(T_PDLOW - 1);
  localparam logic [c_slot_w-1:0] c_sample     = c_slot_w'(T_SAMPLE);
  localparam logic [c_slot_w-1:0] c_hold0      = c_slot_w'(T_HOLD0);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_LOW   = 4'd1,
    S_PD_WAIT   = 4'd2,
    S_PD_LOW    = 4'd3,
    S_ROM_CMD   = 4'd4,
    S_READ_ROM  = 4'd5,
    S_MATCH_ROM = 4'd6,
    S_SEARCH    = 4'd7,
    S_FUNC      = 4'd8
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  prev_q, prev_d;
  logic [c_low_w-1:0]    low_cnt_q, low_cnt_d;
  logic [c_tmr_w-1:0]    tmr_q, tmr_d;
  logic                  slot_act_q, slot_act_d;
  logic                  slot_tx_q, slot_tx_d;
  logic [c_slot_w-1:0]   slot_cnt_q, slot_cnt_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [1:0]            phase_q, phase_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            tx_shift_q, tx_shift_d;
  logic                  tx_pend_q, tx_pend_d;
  logic [2:0]            tx_cnt_q, tx_cnt_d;
  logic                  ow_pull_q, ow_pull_d;
  logic                  selected_q, selected_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  reset_seen_q, reset_seen_d;
  logic                  cmd_error_q, cmd_error_d;

  logic                  w_line;
  logic                  w_fall;
  logic                  w_rise;
  logic                  w_rom_bit;
  logic [7:0]            w_byte_in;
  logic                  w_rx_pt;
  logic                  w_tx_pt;
  logic                  w_rst_hit;
  logic                  w_slot_en;
  logic                  w_slot_tx;
  logic                  w_slot_bit;

  assign w_line    = sync2_q;
  assign w_fall    = prev_q & ~sync2_q;
  assign w_rise    = ~prev_q & sync2_q;
  assign w_rom_bit = ROM_ID[bit_cnt_q];
  assign w_byte_in = {sync2_q, shift_q[7:1]};
  assign w_rx_pt   = slot_act_q & ~slot_tx_q & (slot_cnt_q == c_sample);
  assign w_tx_pt   = slot_act_q & slot_tx_q & (slot_cnt_q == c_hold0);
  assign w_rst_hit = ~sync2_q & (low_cnt_q == c_low_hit);

  // Role of a slot starting now: whether it is answered at all, and if so
  // whether we transmit and which bit.
  always_comb begin
    w_slot_en  = 1'b0;
    w_slot_tx  = 1'b0;
    w_slot_bit = 1'b1;
    case (state_q)
      S_ROM_CMD, S_MATCH_ROM: w_slot_en = 1'b1;
      S_READ_ROM: begin
        w_slot_en  = 1'b1;
        w_slot_tx  = 1'b1;
        w_slot_bit = w_rom_bit;
      end
      S_SEARCH: begin
        w_slot_en = 1'b1;
        if (phase_q == 2'd0) begin
          w_slot_tx  = 1'b1;
          w_slot_bit = w_rom_bit;
        end else if (phase_q == 2'd1) begin
          w_slot_tx  = 1'b1;
          w_slot_bit = ~w_rom_bit;
        end
      end
      S_FUNC: begin
        w_slot_en = 1'b1;
        if (tx_pend_q) begin
          w_slot_tx  = 1'b1;
          w_slot_bit = tx_shift_q[tx_cnt_q];
        end
      end
      default: w_slot_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sync1_d      = ow_in;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    low_cnt_d    = low_cnt_q;
    tmr_d        = tmr_q;
    slot_act_d   = slot_act_q;
    slot_tx_d    = slot_tx_q;
    slot_cnt_d   = slot_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    phase_d      = phase_q;
    shift_d      = shift_q;
    tx_shift_d   = tx_shift_q;
    tx_pend_d    = tx_pend_q;
    tx_cnt_d     = tx_cnt_q;
    ow_pull_d    = ow_pull_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    reset_seen_d = 1'b0;
    cmd_error_d  = 1'b0;

    if (w_line) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != c_low_sat) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end

    if (slot_act_q) begin
      slot_cnt_d = slot_cnt_q + 1'b1;
    end
    if (w_rx_pt || w_tx_pt) begin
      slot_act_d = 1'b0;
    end
    if (w_tx_pt) begin
      ow_pull_d = 1'b0;
    end

    case (state_q)
      S_RST_LOW: begin
        if (w_rise) begin
          state_d = S_PD_WAIT;
          tmr_d   = '0;
        end
      end
      S_PD_WAIT: begin
        if (tmr_q == c_pdhigh_end) begin
          state_d   = S_PD_LOW;
          tmr_d     = '0;
          ow_pull_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_PD_LOW: begin
        if (tmr_q == c_pdlow_end) begin
          state_d   = S_ROM_CMD;
          tmr_d     = '0;
          ow_pull_d = 1'b0;
          bit_cnt_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_ROM_CMD: begin
        if (w_rx_pt) begin
          shift_d   = w_byte_in;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d = '0;
            phase_d   = '0;
            case (w_byte_in)
              8'h33:        state_d = S_READ_ROM;
              8'h55, 8'h69: state_d = S_MATCH_ROM;
              8'hCC, 8'h3C: state_d = S_FUNC;
              8'hF0:        state_d = S_SEARCH;
              8'hEC:        state_d = alarm ? S_SEARCH : S_IDLE;
              default: begin
                state_d     = S_IDLE;
                cmd_error_d = 1'b1;
              end
            endcase
          end
        end
      end
      S_READ_ROM: begin
        if (w_tx_pt) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd63) begin
            bit_cnt_d = '0;
            state_d   = S_FUNC;
          end
        end
      end
      S_MATCH_ROM: begin
        if (w_rx_pt) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (w_line != w_rom_bit) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else if (bit_cnt_q == 6'd63) begin
            bit_cnt_d = '0;
            state_d   = S_FUNC;
          end
        end
      end
      S_SEARCH: begin
        if (w_tx_pt) begin
          phase_d = phase_q + 2'd1;
        end
        if (w_rx_pt) begin
          phase_d   = '0;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (w_line != w_rom_bit) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else if (bit_cnt_q == 6'd63) begin
            bit_cnt_d = '0;
            state_d   = S_FUNC;
          end
        end
      end
      S_FUNC: begin
        if (w_rx_pt) begin
          shift_d   = w_byte_in;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d  = '0;
            rx_data_d  = w_byte_in;
            rx_valid_d = 1'b1;
          end
        end
        if (w_tx_pt) begin
          tx_cnt_d = tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd7) begin
            tx_cnt_d  = '0;
            tx_pend_d = 1'b0;
          end
        end
        if (fn.tx_load && tx_ready_q) begin
          tx_shift_d = fn.tx_data;
          tx_pend_d  = 1'b1;
          tx_cnt_d   = '0;
        end
      end
      default: state_d = state_q;
    endcase

    // A new slot always wins over the tail of the previous one.
    if (w_fall && w_slot_en) begin
      slot_act_d = 1'b1;
      slot_cnt_d = '0;
      slot_tx_d  = w_slot_tx;
      ow_pull_d  = w_slot_tx & ~w_slot_bit;
    end

    // A qualified reset pulse overrides everything in progress.
    if (w_rst_hit) begin
      state_d      = S_RST_LOW;
      reset_seen_d = 1'b1;
      ow_pull_d    = 1'b0;
      slot_act_d   = 1'b0;
      slot_tx_d    = 1'b0;
      slot_cnt_d   = '0;
      bit_cnt_d    = '0;
      phase_d      = '0;
      shift_d      = '0;
      tx_pend_d    = 1'b0;
      tx_cnt_d     = '0;
      tmr_d        = '0;
      rx_valid_d   = 1'b0;
      cmd_error_d  = 1'b0;
    end
  end

  assign selected_d = (state_d == S_FUNC);
  assign tx_ready_d = (state_d == S_FUNC) & ~tx_pend_d;

  always_ff @(posedge clk or posedge local_reset) begin
    if (local_reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      low_cnt_q    <= '0;
      tmr_q        <= '0;
      slot_act_q   <= 1'b0;
      slot_tx_q    <= 1'b0;
      slot_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      phase_q      <= '0;
      shift_q      <= '0;
      tx_shift_q   <= '0;
      tx_pend_q    <= 1'b0;
      tx_cnt_q     <= '0;
      ow_pull_q    <= 1'b0;
      selected_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      reset_seen_q <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      low_cnt_q    <= low_cnt_d;
      tmr_q        <= tmr_d;
      slot_act_q   <= slot_act_d;
      slot_tx_q    <= slot_tx_d;
      slot_cnt_q   <= slot_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      phase_q      <= phase_d;
      shift_q      <= shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_pend_q    <= tx_pend_d;
      tx_cnt_q     <= tx_cnt_d;
      ow_pull_q    <= ow_pull_d;
      selected_q   <= selected_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_ready_q   <= tx_ready_d;
      reset_seen_q <= reset_seen_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  assign ow_pull     = ow_pull_q;
  assign selected    = selected_q;
  assign reset_seen  = reset_seen_q;
  assign cmd_error   = cmd_error_q;
  assign fn.rx_data  = rx_data_q;
  assign fn.rx_valid = rx_valid_q;
  assign fn.tx_ready = tx_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_ow_slave_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ow_slave_rom : bus-master driven bench for the 1-Wire ROM slave    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ow_slave_rom;
  localparam logic [63:0] ROM = 64'hA2000000_12345628;
  localparam int M_READ = 0, M_MATCH = 1, M_FUNC = 2, M_SEARCH = 3, M_IDLE = 4, M_ERR = 5;

  logic clk = 1'b0;
  logic local_reset = 1'b0;
  logic m_pull = 1'b0;
  logic alarm = 1'b0;
  logic ow_pull, selected, reset_seen, cmd_error;
  wire  ow_line;

  assign ow_line = ~(m_pull | ow_pull);

  ow_slave_rom_if bus();

  ow_slave_rom dut (
    .clk         (clk),
    .local_reset (local_reset),
    .ow_in       (ow_line),
    .ow_pull     (ow_pull),
    .alarm       (alarm),
    .selected    (selected),
    .reset_seen  (reset_seen),
    .cmd_error   (cmd_error),
    .fn          (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int rs_cnt = 0;
  int ce_cnt = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (reset_seen) rs_cnt++;
    if (cmd_error) ce_cnt++;
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
  end

  // What a ROM command byte should lead to.
  function automatic int rom_cmd_mode(input logic [7:0] c, input logic alm);
    case (c)
      8'h33:        return M_READ;
      8'h55, 8'h69: return M_MATCH;
      8'hCC, 8'h3C: return M_FUNC;
      8'hF0:        return M_SEARCH;
      8'hEC:        return alm ? M_SEARCH : M_IDLE;
      default:      return M_ERR;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slot_write(input logic b);
    m_pull = 1'b1;
    cyc(b ? 6 : 60);
    m_pull = 1'b0;
    cyc(b ? 69 : 15);
  endtask

  task automatic slot_read(output logic b);
    m_pull = 1'b1;
    cyc(3);
    m_pull = 1'b0;
    cyc(12);
    b = ow_line;
    cyc(60);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) slot_write(v[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      slot_read(b);
      v[i] = b;
    end
  endtask

  task automatic bus_reset(input int len, output int seen, output int first, output int width);
    int rs0;
    rs0 = rs_cnt;
    m_pull = 1'b1;
    cyc(len);
    m_pull = 1'b0;
    first = -1;
    width = 0;
    for (int c = 1; c <= 200; c++) begin
      cyc(1);
      if (ow_pull) begin
        if (first < 0) first = c;
        width++;
      end
    end
    seen = rs_cnt - rs0;
  endtask

  task automatic full_reset(input string tag);
    int seen, first, width;
    bus_reset(480, seen, first, width);
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic search_run(input logic active, input int nbits, output int errs);
    logic b1, b2;
    errs = 0;
    for (int i = 0; i < nbits; i++) begin
      slot_read(b1);
      slot_read(b2);
      if (active ? ({b1, b2} !== {ROM[i], ~ROM[i]}) : ({b1, b2} !== 2'b11)) errs++;
      slot_write(ROM[i]);
    end
  endtask

  task automatic match_run(input logic [7:0] cmd, input int flip, output int pulls);
    logic b;
    pulls = 0;
    write_byte(cmd);
    for (int i = 0; i < 64; i++) begin
      if (flip >= 0 && i > flip) begin
        slot_read(b);
        if (!b) pulls++;
      end else begin
        slot_write(ROM[i] ^ (i == flip));
      end
    end
  endtask

  task automatic load_tx(input logic [7:0] v, input string tag);
    int k;
    k = 0;
    while (!bus.tx_ready && k < 20) begin
      cyc(1);
      k++;
    end
    check({tag, "_ready_wait"}, 64'(bus.tx_ready), 64'd1);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    cyc(1);
    bus.tx_load = 1'b0;
    check({tag, "_ready_drop"}, 64'(bus.tx_ready), 64'd0);
  endtask

  initial begin
    int seen, first, width, errs, pulls, idx, ce0;
    logic [63:0] rd;
    logic [7:0] v, a, c;
    logic b;

    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    #1 local_reset = 1'b1;
    cyc(3);
    check("rst_ow_pull", 64'(ow_pull), 64'd0);
    check("rst_selected", 64'(selected), 64'd0);
    check("rst_rx_data", 64'(bus.rx_data), 64'd0);
    check("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
    check("rst_tx_ready", 64'(bus.tx_ready), 64'd0);
    check("rst_reset_seen", 64'(reset_seen), 64'd0);
    check("rst_cmd_error", 64'(cmd_error), 64'd0);
    local_reset = 1'b0;
    cyc(5);

    // Short low pulse is not a reset.
    bus_reset(300, seen, first, width);
    check("short_low_reset_seen", 64'(seen), 64'd0);
    check("short_low_presence", 64'(width), 64'd0);
    check("short_low_selected", 64'(selected), 64'd0);

    // Qualified reset and presence timing.
    bus_reset(480, seen, first, width);
    check("reset_seen_count", 64'(seen), 64'd1);
    check("presence_start", 64'((first >= 32) && (first <= 35)), 64'd1);
    check("presence_width", 64'(width), 64'd120);

    // READ ROM
    write_byte(8'h33);
    for (int i = 0; i < 64; i++) begin
      slot_read(b);
      rd[i] = b;
    end
    check("read_rom_id", rd, ROM);
    check("read_rom_selected", 64'(selected), 64'(rom_cmd_mode(8'h33, 1'b0) == M_READ));
    check("read_rom_tx_ready", 64'(bus.tx_ready), 64'd1);

    // MATCH ROM with bit 9 flipped, then a random flip, then a clean match.
    full_reset("match9_reset");
    match_run(8'h55, 9, pulls);
    check("match9_selected", 64'(selected), 64'd0);
    check("match9_silent", 64'(pulls), 64'd0);
    full_reset("match_rand_reset");
    idx = $urandom_range(0, 62);
    match_run(8'h69, idx, pulls);
    check("match_rand_selected", 64'(selected), 64'd0);
    check("match_rand_silent", 64'(pulls), 64'd0);
    full_reset("match_ok_reset");
    match_run(8'h55, -1, pulls);
    check("match_ok_selected", 64'(selected), 64'd1);

    // SEARCH ROM
    full_reset("search_reset");
    alarm = 1'b0;
    write_byte(8'hF0);
    search_run(rom_cmd_mode(8'hF0, alarm) == M_SEARCH, 64, errs);
    check("search_pattern_errs", 64'(errs), 64'd0);
    check("search_selected", 64'(selected), 64'd1);
    full_reset("alarm0_reset");
    write_byte(8'hEC);
    search_run(rom_cmd_mode(8'hEC, alarm) == M_SEARCH, 6, errs);
    check("alarm0_silent_errs", 64'(errs), 64'd0);
    check("alarm0_selected", 64'(selected), 64'd0);
    full_reset("alarm1_reset");
    alarm = 1'b1;
    write_byte(8'hEC);
    search_run(rom_cmd_mode(8'hEC, alarm) == M_SEARCH, 6, errs);
    check("alarm1_pattern_errs", 64'(errs), 64'd0);
    alarm = 1'b0;

    // Unsupported ROM command
    full_reset("bad_cmd_reset");
    do c = 8'($urandom); while (rom_cmd_mode(c, 1'b0) != M_ERR);
    ce0 = ce_cnt;
    write_byte(c);
    check("bad_cmd_error_pulse", 64'(ce_cnt - ce0), 64'd1);
    check("bad_cmd_selected", 64'(selected), 64'd0);

    // SKIP ROM into function phase: receive
    full_reset("func_reset");
    write_byte(8'hCC);
    check("func_selected", 64'(selected), 64'd1);
    rx_q.delete();
    a = 8'($urandom);
    write_byte(8'hA5);
    write_byte(a);
    check("func_rx_count", 64'(rx_q.size()), 64'd2);
    if (rx_q.size() == 2) begin
      check("func_rx_a5", 64'(rx_q[0]), 64'h A5);
      check("func_rx_rand", 64'(rx_q[1]), 64'(a));
    end
    check("func_rx_data_reg", 64'(bus.rx_data), 64'(a));

    // Transmit
    load_tx(8'h3C, "tx3c");
    read_byte(v);
    check("tx_3c_byte", 64'(v), 64'h3C);
    cyc(2);
    check("tx_ready_back", 64'(bus.tx_ready), 64'd1);
    a = 8'($urandom);
    c = ~a;
    load_tx(a, "txrand");
    bus.tx_data = c;
    bus.tx_load = 1'b1;
    cyc(1);
    bus.tx_load = 1'b0;
    read_byte(v);
    check("tx_ignored_load", 64'(v), 64'(a));

    // Reset in the middle of a pending transmit byte
    load_tx(8'h00, "txmid");
    for (int i = 0; i < 3; i++) slot_read(b);
    bus_reset(480, seen, first, width);
    check("midbyte_reset_seen", 64'(seen), 64'd1);
    check("midbyte_selected", 64'(selected), 64'd0);
    check("midbyte_tx_ready", 64'(bus.tx_ready), 64'd0);
    check("midbyte_presence", 64'(width), 64'd120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
